// File: rtl/ca_pkg.sv
// Shared opcodes, mode-register addresses, FSM states, field encodings and
// reset defaults for the CA command decoder.
package ca_pkg;

  localparam int CA_W = 14;

  localparam logic [4:0] OPC_WR  = 5'b01101;
  localparam logic [4:0] OPC_MRW = 5'b00101;

  localparam logic [7:0] MA_MR0  = 8'd0;
  localparam logic [7:0] MA_MR8  = 8'd8;
  localparam logic [7:0] MA_MR50 = 8'd50;

  typedef enum logic [1:0] {IDLE, WR2, MRW2, SKIP2} state_e;

  // Burst-length mode as carried in MR0 OP[1:0]
  localparam logic [1:0] BLM_16      = 2'b00;
  localparam logic [1:0] BLM_BC8_OTF = 2'b01;
  localparam logic [1:0] BLM_32      = 2'b10;
  localparam logic [1:0] BLM_RSVD    = 2'b11;

  // Write preamble as carried in MR8 OP[4:3]
  localparam logic [1:0] PRE_RSVD = 2'b00;
  localparam logic [1:0] PRE_2CK  = 2'b01;
  localparam logic [1:0] PRE_3CK  = 2'b10;
  localparam logic [1:0] PRE_4CK  = 2'b11;

  localparam logic [5:0] DEF_BURST_LEN   = 6'd16;
  localparam logic [7:0] DEF_PRE_PATTERN = 8'b00000010;
  localparam logic [2:0] DEF_PRE_CYCLE   = 3'd2;
  localparam logic [1:0] DEF_POST_CYCLE  = 2'd1;

  localparam logic [1:0] DEF_SH_BL   = BLM_16;
  localparam logic [1:0] DEF_SH_PRE  = PRE_2CK;
  localparam logic       DEF_SH_POST = 1'b0;
  localparam logic       DEF_SH_CRC  = 1'b0;

  function automatic logic [7:0] pre_pattern_of(input logic [1:0] enc);
    case (enc)
      PRE_3CK: pre_pattern_of = 8'b00000100;
      PRE_4CK: pre_pattern_of = 8'b00001010;
      default: pre_pattern_of = 8'b00000010;
    endcase
  endfunction

  function automatic logic [2:0] pre_cycles_of(input logic [1:0] enc);
    case (enc)
      PRE_3CK: pre_cycles_of = 3'd3;
      PRE_4CK: pre_cycles_of = 3'd4;
      default: pre_cycles_of = 3'd2;
    endcase
  endfunction

  // BC8-OTF picks the length per write from the BL* bit of the command
  function automatic logic [5:0] burst_len_of(input logic [1:0] blm, input logic bl_star);
    case (blm)
      BLM_32:      burst_len_of = 6'd32;
      BLM_BC8_OTF: burst_len_of = bl_star ? 6'd16 : 6'd8;
      default:     burst_len_of = 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/ca_delay_line.sv
// Fixed-depth register delay line; reset fills every stage with RST_VAL.
module ca_delay_line #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/ca_cmd_decoder.sv
// Two-cycle CA command decoder: delays CA/CS_n and tracks per-rank write mode
// registers. Define CMD_ERR_CHECK_EN to add the cmd_err protocol-error pulse.
module ca_cmd_decoder
  import ca_pkg::*;
#(
  parameter int NUM_RANK   = 1,
  parameter int CA_LATENCY = 1,
  localparam int RANK_W    = (NUM_RANK > 1) ? $clog2(NUM_RANK) : 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [13:0]         dfi_address,
  input  logic [NUM_RANK-1:0] dfi_cs_n,
  output logic [NUM_RANK-1:0] CS_n,
  output logic [13:0]         CA,
  output logic                wr_valid,
  output logic [RANK_W-1:0]   wr_rank,
  output logic                wr_ap,
  output logic [5:0]          wr_burst_length,
  output logic                wr_crc_en,
  output logic [7:0]          pre_pattern,
  output logic [2:0]          pre_cycle,
`ifdef CMD_ERR_CHECK_EN
  output logic                cmd_err,
`endif
  output logic [1:0]          post_cycle
);

  logic [NUM_RANK-1:0] w_cs_n;
  logic [13:0]         w_ca;
  logic                w_cmd_sel;
  logic [NUM_RANK+13:0] w_pipe_out;

  // A disabled block looks exactly like a deselected bus to everything downstream
  assign w_cs_n    = i_enable ? dfi_cs_n : '1;
  assign w_ca      = i_enable ? dfi_address : '0;
  assign w_cmd_sel = ~&w_cs_n;

  ca_delay_line #(
    .WIDTH  (NUM_RANK + 14),
    .DEPTH  (CA_LATENCY),
    .RST_VAL({{NUM_RANK{1'b1}}, 14'd0})
  ) u_delay (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_data ({w_cs_n, w_ca}),
    .o_data (w_pipe_out)
  );

  assign CS_n = w_pipe_out[NUM_RANK+13:14];
  assign CA   = w_pipe_out[13:0];

  state_e              r_state;
  logic [NUM_RANK-1:0] r_mask;
  logic [7:0]          r_ma;
  logic                r_bl_star;

  logic [1:0] r_sh_bl   [NUM_RANK];
  logic [1:0] r_sh_pre  [NUM_RANK];
  logic       r_sh_post [NUM_RANK];
  logic       r_sh_crc  [NUM_RANK];

  logic              w_one_rank;
  logic [RANK_W-1:0] w_rank_idx;
  logic [1:0]        w_sel_bl;
  logic [1:0]        w_sel_pre;
  logic              w_sel_post;
  logic              w_sel_crc;

  // Shadow fields of the (single) rank picked by the latched mask
  always_comb begin
    w_one_rank = ($countones(~r_mask) == 1);
    w_rank_idx = '0;
    w_sel_bl   = DEF_SH_BL;
    w_sel_pre  = DEF_SH_PRE;
    w_sel_post = DEF_SH_POST;
    w_sel_crc  = DEF_SH_CRC;
    for (int r = 0; r < NUM_RANK; r++) begin
      if (!r_mask[r]) begin
        w_rank_idx = RANK_W'(r);
        w_sel_bl   = r_sh_bl[r];
        w_sel_pre  = r_sh_pre[r];
        w_sel_post = r_sh_post[r];
        w_sel_crc  = r_sh_crc[r];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state         <= IDLE;
      r_mask          <= '1;
      r_ma            <= '0;
      r_bl_star       <= 1'b0;
      wr_valid        <= 1'b0;
      wr_rank         <= '0;
      wr_ap           <= 1'b0;
      wr_burst_length <= DEF_BURST_LEN;
      wr_crc_en       <= 1'b0;
      pre_pattern     <= DEF_PRE_PATTERN;
      pre_cycle       <= DEF_PRE_CYCLE;
      post_cycle      <= DEF_POST_CYCLE;
      for (int r = 0; r < NUM_RANK; r++) begin
        r_sh_bl[r]   <= DEF_SH_BL;
        r_sh_pre[r]  <= DEF_SH_PRE;
        r_sh_post[r] <= DEF_SH_POST;
        r_sh_crc[r]  <= DEF_SH_CRC;
      end
    end else begin
      wr_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmd_sel) begin
            r_mask    <= w_cs_n;
            r_ma      <= w_ca[12:5];
            r_bl_star <= w_ca[5];
            if (w_ca[4:0] == OPC_WR)       r_state <= WR2;
            else if (w_ca[4:0] == OPC_MRW) r_state <= MRW2;
            else if (!w_ca[1])             r_state <= SKIP2;
          end
        end
        WR2: begin
          r_state <= IDLE;
          if (w_one_rank) begin
            wr_valid        <= 1'b1;
            wr_rank         <= w_rank_idx;
            wr_ap           <= ~w_ca[10];
            wr_burst_length <= burst_len_of(w_sel_bl, r_bl_star);
            wr_crc_en       <= w_sel_crc;
            pre_pattern     <= pre_pattern_of(w_sel_pre);
            pre_cycle       <= pre_cycles_of(w_sel_pre);
            post_cycle      <= w_sel_post ? 2'd2 : 2'd1;
          end
        end
        MRW2: begin
          r_state <= IDLE;
          for (int r = 0; r < NUM_RANK; r++) begin
            if (!r_mask[r]) begin
              case (r_ma)
                MA_MR0: if (w_ca[1:0] != BLM_RSVD) r_sh_bl[r] <= w_ca[1:0];
                MA_MR8: begin
                  if (w_ca[4:3] != PRE_RSVD) r_sh_pre[r] <= w_ca[4:3];
                  r_sh_post[r] <= w_ca[7];
                end
                MA_MR50: r_sh_crc[r] <= w_ca[2];
                default: ;
              endcase
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CMD_ERR_CHECK_EN
  logic w_err;

  always_comb begin
    w_err = 1'b0;
    if (r_state != IDLE && w_cmd_sel) w_err = 1'b1;
    if (r_state == WR2 && !w_one_rank) w_err = 1'b1;
    if (r_state == MRW2 && r_ma == MA_MR0 && w_ca[1:0] == BLM_RSVD) w_err = 1'b1;
    if (r_state == MRW2 && r_ma == MA_MR8 && w_ca[4:3] == PRE_RSVD) w_err = 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) cmd_err <= 1'b0;
    else          cmd_err <= w_err;
  end
`endif

endmodule

// File: tb/tb_ca_cmd_decoder.sv
// Bench for ca_cmd_decoder: a single-rank latency-1 instance and a two-rank
// latency-3 instance share one stimulus stream and are checked against a model.
module tb_ca_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  cs;
  logic [13:0] ca;

  always #5 clk = ~clk;

  logic        d0_cs;
  logic [13:0] d0_ca;
  logic        d0_valid, d0_rank, d0_ap, d0_crc;
  logic [5:0]  d0_bl;
  logic [7:0]  d0_pp;
  logic [2:0]  d0_pc;
  logic [1:0]  d0_post;
  logic [1:0]  d1_cs;
  logic [13:0] d1_ca;
  logic        d1_valid, d1_rank, d1_ap, d1_crc;
  logic [5:0]  d1_bl;
  logic [7:0]  d1_pp;
  logic [2:0]  d1_pc;
  logic [1:0]  d1_post;
`ifdef CMD_ERR_CHECK_EN
  logic        d0_err, d1_err;
`endif

  ca_cmd_decoder #(.NUM_RANK(1), .CA_LATENCY(1)) u_dut0 (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en),
    .dfi_address(ca), .dfi_cs_n(cs[0:0]),
    .CS_n(d0_cs), .CA(d0_ca), .wr_valid(d0_valid), .wr_rank(d0_rank),
    .wr_ap(d0_ap), .wr_burst_length(d0_bl), .wr_crc_en(d0_crc),
    .pre_pattern(d0_pp), .pre_cycle(d0_pc),
`ifdef CMD_ERR_CHECK_EN
    .cmd_err(d0_err),
`endif
    .post_cycle(d0_post)
  );

  ca_cmd_decoder #(.NUM_RANK(2), .CA_LATENCY(3)) u_dut1 (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en),
    .dfi_address(ca), .dfi_cs_n(cs),
    .CS_n(d1_cs), .CA(d1_ca), .wr_valid(d1_valid), .wr_rank(d1_rank),
    .wr_ap(d1_ap), .wr_burst_length(d1_bl), .wr_crc_en(d1_crc),
    .pre_pattern(d1_pp), .pre_cycle(d1_pc),
`ifdef CMD_ERR_CHECK_EN
    .cmd_err(d1_err),
`endif
    .post_cycle(d1_post)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per instance, a history of bus words, a pending first command word,
  // per-rank mode settings (bl mode 0=BL16 1=BC8-OTF 2=BL32, preamble in clocks,
  // postamble in clocks) and the expected outputs.
  logic [15:0] m_hist [2][4];
  int          m_pend [2];
  logic [1:0]  m_pcs  [2];
  logic [7:0]  m_pma  [2];
  logic        m_pbs  [2];
  int          m_bl   [2][2];
  logic        m_crc  [2][2];
  int          m_pre  [2][2];
  int          m_post [2][2];
  bit          m_live [2];
  logic        e_valid[2], e_rank[2], e_ap[2], e_crc[2], e_err[2];
  logic [5:0]  e_bl   [2];
  logic [7:0]  e_pp   [2];
  logic [2:0]  e_pc   [2];
  logic [1:0]  e_post [2];

  task automatic model_step(input int d);
    logic [1:0]  c;
    logic [13:0] a;
    logic [7:0]  op;
    int          nlow, rk;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_hist[d][i] = {2'b11, 14'd0};
      m_pend[d] = 0;
      for (int r = 0; r < 2; r++) begin
        m_bl[d][r] = 0; m_crc[d][r] = 1'b0; m_pre[d][r] = 2; m_post[d][r] = 1;
      end
      e_valid[d] = 0; e_rank[d] = 0; e_ap[d] = 0; e_bl[d] = 16; e_crc[d] = 0;
      e_pp[d] = 8'b00000010; e_pc[d] = 2; e_post[d] = 1; e_err[d] = 0;
      m_live[d] = 1'b1;
      return;
    end
    c = en ? cs : 2'b11;
    a = en ? ca : 14'd0;
    if (d == 0) c[1] = 1'b1;
    for (int i = 3; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
    m_hist[d][0] = {c, a};
    e_valid[d] = 0;
    e_err[d]   = 0;
    if (m_pend[d] != 0) begin
      if (c != 2'b11) e_err[d] = 1;
      if (m_pend[d] == 1) begin
        nlow = 0;
        for (int r = 0; r < 2; r++) if (!m_pcs[d][r]) nlow++;
        if (nlow == 1) begin
          rk = m_pcs[d][0] ? 1 : 0;
          e_valid[d] = 1;
          e_rank[d]  = rk[0];
          e_ap[d]    = ~a[10];
          e_bl[d]    = (m_bl[d][rk] == 2) ? 6'd32 :
                       (m_bl[d][rk] == 1 && !m_pbs[d]) ? 6'd8 : 6'd16;
          e_crc[d]   = m_crc[d][rk];
          e_pc[d]    = 3'(m_pre[d][rk]);
          e_pp[d]    = (m_pre[d][rk] == 4) ? 8'b00001010 :
                       (m_pre[d][rk] == 3) ? 8'b00000100 : 8'b00000010;
          e_post[d]  = 2'(m_post[d][rk]);
        end else begin
          e_err[d] = 1;
        end
      end else if (m_pend[d] == 2) begin
        op = a[7:0];
        if (m_pma[d] == 8'd0 && op[1:0] == 2'b11) e_err[d] = 1;
        if (m_pma[d] == 8'd8 && op[4:3] == 2'b00) e_err[d] = 1;
        for (int r = 0; r < 2; r++) begin
          if (!m_pcs[d][r]) begin
            if (m_pma[d] == 8'd0 && op[1:0] != 2'b11) m_bl[d][r] = int'(op[1:0]);
            if (m_pma[d] == 8'd8) begin
              if (op[4:3] != 2'b00) m_pre[d][r] = int'(op[4:3]) + 1;
              m_post[d][r] = op[7] ? 2 : 1;
            end
            if (m_pma[d] == 8'd50) m_crc[d][r] = op[2];
          end
        end
      end
      m_pend[d] = 0;
    end else if (c != 2'b11) begin
      m_pcs[d] = c;
      m_pma[d] = a[12:5];
      m_pbs[d] = a[5];
      if (a[4:0] == 5'b01101)      m_pend[d] = 1;
      else if (a[4:0] == 5'b00101) m_pend[d] = 2;
      else if (!a[1])              m_pend[d] = 3;
    end
  endtask

  initial begin
    m_live[0] = 1'b0;
    m_live[1] = 1'b0;
  end

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (m_live[0] && m_live[1]) begin
      chk("d0_CS_n", 32'(d0_cs), 32'(m_hist[0][0][14]));
      chk("d0_CA", 32'(d0_ca), 32'(m_hist[0][0][13:0]));
      chk("d0_wr_valid", 32'(d0_valid), 32'(e_valid[0]));
      chk("d0_wr_rank", 32'(d0_rank), 32'(e_rank[0]));
      chk("d0_wr_ap", 32'(d0_ap), 32'(e_ap[0]));
      chk("d0_wr_bl", 32'(d0_bl), 32'(e_bl[0]));
      chk("d0_wr_crc", 32'(d0_crc), 32'(e_crc[0]));
      chk("d0_pre_pattern", 32'(d0_pp), 32'(e_pp[0]));
      chk("d0_pre_cycle", 32'(d0_pc), 32'(e_pc[0]));
      chk("d0_post_cycle", 32'(d0_post), 32'(e_post[0]));
      chk("d1_CS_n", 32'(d1_cs), 32'(m_hist[1][2][15:14]));
      chk("d1_CA", 32'(d1_ca), 32'(m_hist[1][2][13:0]));
      chk("d1_wr_valid", 32'(d1_valid), 32'(e_valid[1]));
      chk("d1_wr_rank", 32'(d1_rank), 32'(e_rank[1]));
      chk("d1_wr_ap", 32'(d1_ap), 32'(e_ap[1]));
      chk("d1_wr_bl", 32'(d1_bl), 32'(e_bl[1]));
      chk("d1_wr_crc", 32'(d1_crc), 32'(e_crc[1]));
      chk("d1_pre_pattern", 32'(d1_pp), 32'(e_pp[1]));
      chk("d1_pre_cycle", 32'(d1_pc), 32'(e_pc[1]));
      chk("d1_post_cycle", 32'(d1_post), 32'(e_post[1]));
`ifdef CMD_ERR_CHECK_EN
      chk("d0_cmd_err", 32'(d0_err), 32'(e_err[0]));
      chk("d1_cmd_err", 32'(d1_err), 32'(e_err[1]));
`endif
    end
  end

  task automatic tick(input logic r, input logic e, input logic [1:0] c, input logic [13:0] a);
    rst_n = r;
    en    = e;
    cs    = c;
    ca    = a;
    @(negedge clk);
  endtask

  task automatic cmd(input logic [1:0] c, input logic [13:0] a);
    tick(1'b1, 1'b1, c, a);
  endtask

  task automatic idle();
    tick(1'b1, 1'b1, 2'b11, 14'd0);
  endtask

  localparam logic [13:0] WR_A  = 14'b10100000001101;
  localparam logic [13:0] WR_B  = 14'b11010000001101;
  localparam logic [13:0] MRW8  = 14'b00000100000101;
  localparam logic [13:0] MRW0  = {1'b0, 8'd0, 5'b00101};
  localparam logic [13:0] MRW50 = {1'b0, 8'd50, 5'b00101};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; cs = 2'b11; ca = 14'd0;
    @(negedge clk);
    tick(1'b0, 1'b1, 2'b11, 14'd0);
    chk("rst_cs0", 32'(d0_cs), 32'h1);
    chk("rst_cs1", 32'(d1_cs), 32'h3);
    chk("rst_ca", 32'(d0_ca), 32'h0);
    chk("rst_valid", 32'(d0_valid), 32'h0);
    chk("rst_bl", 32'(d0_bl), 32'd16);
    chk("rst_pp", 32'(d0_pp), 32'h02);
    chk("rst_pc", 32'(d0_pc), 32'd2);
    chk("rst_post", 32'(d0_post), 32'd1);
    idle();

    // Basic write, CA/CS_n echo
    cmd(2'b10, WR_A);
    chk("echo_ca1", 32'(d0_ca), 32'(WR_A));
    chk("echo_cs1", 32'(d0_cs), 32'h0);
    cmd(2'b11, WR_B);
    chk("wr_valid", 32'(d0_valid), 32'h1);
    chk("echo_ca2", 32'(d0_ca), 32'(WR_B));
    chk("wr_bl16", 32'(d0_bl), 32'd16);
    chk("wr_ap0", 32'(d0_ap), 32'h0);
    idle();
    chk("wr_pulse_end", 32'(d0_valid), 32'h0);

    // MR8 to 4-clock preamble, 2-clock postamble
    cmd(2'b10, MRW8);
    cmd(2'b11, 14'b00000010011000);
    idle();
    cmd(2'b10, WR_A);
    cmd(2'b11, WR_B);
    chk("mr8_pc", 32'(d0_pc), 32'd4);
    chk("mr8_pp", 32'(d0_pp), 32'h0A);
    chk("mr8_post", 32'(d0_post), 32'd2);

    // MRW immediately followed by WR uses the new setting
    cmd(2'b10, MRW8);
    cmd(2'b11, 14'b00000000001000);
    cmd(2'b10, WR_A);
    cmd(2'b11, WR_B);
    chk("b2b_pc", 32'(d0_pc), 32'd2);
    chk("b2b_post", 32'(d0_post), 32'd1);

    // Per-rank CRC enable
    cmd(2'b01, MRW50);
    cmd(2'b11, 14'd6);
    cmd(2'b10, WR_A);
    cmd(2'b11, WR_B);
    chk("crc_r0_valid", 32'(d1_valid), 32'h1);
    chk("crc_r0_rank", 32'(d1_rank), 32'h0);
    chk("crc_r0_en", 32'(d1_crc), 32'h0);
    cmd(2'b01, WR_A);
    cmd(2'b11, WR_B);
    chk("crc_r1_rank", 32'(d1_rank), 32'h1);
    chk("crc_r1_en", 32'(d1_crc), 32'h1);
    chk("d0_r1_ignored", 32'(d0_valid), 32'h0);

    // BC8-OTF and BL32
    cmd(2'b00, MRW0);
    cmd(2'b11, 14'd1);
    cmd(2'b10, 14'b00000000001101);
    cmd(2'b11, 14'd0);
    chk("otf_bl8", 32'(d0_bl), 32'd8);
    chk("otf_ap1", 32'(d0_ap), 32'h1);
    cmd(2'b10, 14'b00000000101101);
    cmd(2'b11, 14'h400);
    chk("otf_bl16", 32'(d0_bl), 32'd16);
    cmd(2'b00, MRW0);
    cmd(2'b11, 14'd2);
    cmd(2'b10, WR_A);
    cmd(2'b11, WR_B);
    chk("bl32", 32'(d0_bl), 32'd32);

    // Reserved encodings leave shadows alone
    cmd(2'b00, MRW0);
    cmd(2'b11, 14'd3);
    cmd(2'b10, WR_A);
    cmd(2'b11, WR_B);
    chk("rsvd_mr0_bl", 32'(d0_bl), 32'd32);
    cmd(2'b10, MRW8);
    cmd(2'b11, 14'h080);
    idle();

    // Multi-rank write
    cmd(2'b00, WR_A);
    cmd(2'b11, WR_B);
    chk("multi_d1_valid", 32'(d1_valid), 32'h0);
    chk("multi_d0_valid", 32'(d0_valid), 32'h1);
`ifdef CMD_ERR_CHECK_EN
    chk("multi_err", 32'(d1_err), 32'h1);
`endif

    // cs_n low in the second cycle never starts a command
    cmd(2'b10, WR_A);
    cmd(2'b10, WR_B);
    idle();
    chk("cs2_no_start", 32'(d0_valid), 32'h0);

    // Two-cycle unknown command swallows the next word; one-cycle does not
    cmd(2'b10, 14'b00000000001001);
    cmd(2'b10, WR_A);
    cmd(2'b11, WR_B);
    chk("skip_no_wr", 32'(d0_valid), 32'h0);
    cmd(2'b10, 14'b00000000011111);
    cmd(2'b10, WR_A);
    cmd(2'b11, WR_B);
    chk("one_cyc_wr", 32'(d0_valid), 32'h1);

    // Enable low looks like deselect
    tick(1'b1, 1'b0, 2'b10, WR_A);
    chk("dis_ca", 32'(d0_ca), 32'h0);
    chk("dis_cs", 32'(d0_cs), 32'h1);
    tick(1'b1, 1'b0, 2'b11, WR_B);
    chk("dis_valid", 32'(d0_valid), 32'h0);
    idle();
    idle();
    idle();

    // Reset in the middle of a write
    cmd(2'b10, WR_A);
    tick(1'b0, 1'b1, 2'b11, WR_B);
    chk("mid_rst_valid", 32'(d1_valid), 32'h0);
    chk("mid_rst_bl", 32'(d0_bl), 32'd16);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("mid_rst_cs", 32'(d1_cs), 32'h3);
      chk("mid_rst_valid2", 32'(d1_valid), 32'h0);
    end
    cmd(2'b01, WR_A);
    cmd(2'b11, WR_B);
    chk("post_rst_crc", 32'(d1_crc), 32'h0);
    chk("post_rst_valid", 32'(d1_valid), 32'h1);
    idle();
    idle();
    idle();
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ca_cmd_decoder.md
CA_CMD_DECODER -- requirements
Module: ca_cmd_decoder

Interface
REQ-001 SHALL have parameter NUM_RANK, default 1, number of chip selects (legal 1..4).
REQ-002 SHALL have parameter CA_LATENCY, default 1, clocks of CA/CS_n passthrough delay (legal 1..4).
REQ-003 SHALL have ports: i_clock in 1, sole clock, rising edge; i_reset in 1, synchronous, active-low.
REQ-004 SHALL have ports: i_enable in 1, block enable; dfi_address in 14, DFI CA; dfi_cs_n in NUM_RANK, DFI chip selects, active-low.
REQ-005 SHALL have outputs: CS_n NUM_RANK, delayed chip selects; CA 14, delayed command/address.
REQ-006 SHALL have outputs: wr_valid 1, write pulse; wr_rank max(1,clog2(NUM_RANK)), write target rank; wr_ap 1, auto-precharge.
REQ-007 SHALL have outputs: wr_burst_length 6; wr_crc_en 1; pre_pattern 8; pre_cycle 3; post_cycle 2; all describe the latest write.

Function
REQ-008 SHALL drive CA/CS_n equal to dfi_address/dfi_cs_n delayed exactly CA_LATENCY clocks.
REQ-009 SHALL, with i_enable low, treat inputs as deselect (cs_n all 1, CA 0) for both the pipeline and the decoder.
REQ-010 SHALL use FSM states IDLE, WR2, MRW2, SKIP2; any second-cycle state returns to IDLE after exactly one clock.
REQ-011 SHALL, in IDLE with any cs_n bit low, decode CA[4:0]: 01101 -> WR2; 00101 -> MRW2; other with CA[1]=0 -> SKIP2; else stay IDLE.
REQ-012 SHALL latch, on leaving IDLE, the cs_n mask, the MR address CA[12:5], and the BL* bit CA[5].
REQ-013 SHALL keep one mode-register shadow per rank: BL mode, write CRC enable, write preamble, write postamble.
REQ-014 SHALL, on the MRW2 cycle, update every rank selected in the latched mask; the new value is visible from the next clock.
REQ-015 SHALL decode MR0 OP[1:0]: 00 BL16, 01 BC8-OTF, 10 BL32, 11 reserved (shadow unchanged).
REQ-016 SHALL decode MR8 OP[4:3]: 01 -> 2 cycles/00000010, 10 -> 3/00000100, 11 -> 4/00001010, 00 reserved (unchanged); OP[7]: 0 -> post_cycle 1, 1 -> post_cycle 2.
REQ-017 SHALL decode MR50 OP[2] as write CRC enable; every other MR address is ignored.
REQ-018 SHALL, on the WR2 cycle with exactly one rank latched, pulse wr_valid for one clock on the next edge.
REQ-019 SHALL, with that pulse, load wr_rank, wr_ap = ~CA[10], and that rank's shadow fields; all hold until the next write.
REQ-020 SHALL set wr_burst_length to 16, 32, or under BC8-OTF 16 when BL*=1 and 8 when BL*=0.
REQ-021 SHALL, for a WR whose latched mask selects more than one rank, suppress wr_valid.
REQ-022 SHALL, when an MRW2 cycle is followed directly by a WR cycle 1 to the same rank, make the WR use the updated shadow.
REQ-023 SHALL ignore cs_n during second-cycle states; it never starts a new command.

Reset
REQ-024 SHALL, on a clock edge with i_reset low (including mid-command), return the FSM to IDLE, fill the pipeline with deselect, and restore defaults.
REQ-025 SHALL use these reset/default values: CS_n all 1, CA 0, wr_valid 0, wr_rank 0, wr_ap 0, wr_burst_length 16, wr_crc_en 0, pre_pattern 00000010, pre_cycle 2, post_cycle 1.
REQ-026 SHALL reset every rank shadow to BL16, CRC off, 2-cycle preamble, postamble 0.

Configuration
REQ-027 SHALL, with macro CMD_ERR_CHECK_EN defined, add output cmd_err (1 bit, reset 0).
REQ-028 SHALL pulse cmd_err for one clock on: a reserved MR0/MR8 encoding, a multi-rank WR, or cs_n low during a second-cycle state.
REQ-029 SHALL, without CMD_ERR_CHECK_EN, have no cmd_err port and leave all other behaviour identical.

Structure
REQ-030 SHALL put in package ca_pkg: opcode constants (WR, MRW), MR addresses (0, 8, 50), FSM state enum, BL/preamble encodings, and reset defaults.
REQ-031 SHALL implement the CA/CS_n delay as sub-module ca_delay_line, parametrised by width and depth.

Verification
REQ-032 SHALL cover: NUM_RANK=1, CA_LATENCY=1; drive WR 10100000001101 then 11010000001101 -> CA/CS_n echo one clock later; wr_valid pulse; wr_burst_length 16; wr_ap 0.
REQ-033 SHALL cover: MRW 00000100000101 then OP 00000010011000, then a WR -> pre_cycle 4, pre_pattern 00001010, post_cycle 2.
REQ-034 SHALL cover: NUM_RANK=2; MRW MR50 OP 00000110 to rank 1 only; WR to ranks 0 then 1 -> wr_crc_en 0 then 1, wr_rank 0 then 1.
REQ-035 SHALL cover: MR0 OP 01 (BC8-OTF); WR with CA[5]=0 -> wr_burst_length 8; then CA[5]=1 -> 16; then MR0 OP 10 and a WR -> 32.
REQ-036 SHALL cover: CA_LATENCY=3; i_reset low during WR2 -> no wr_valid, CS_n all 1 for 3 clocks; with CMD_ERR_CHECK_EN, a WR with cs_n 00 -> cmd_err pulse and no wr_valid.
